// File: rtl/input_s2p_pkg.sv
// Shared types for the serial-to-parallel receiver: FSM state encoding and
// the bit-counter width helper.
package input_s2p_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/s2p_out_buffer.sv
// One-entry valid/ready holding register. Owns the commit decision and the
// overrun pulse raised when a completed word finds the entry still occupied.
module s2p_out_buffer #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          commit_i,
  input  logic [DW-1:0] word_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          overrun_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          overrun_q;
  logic          load;

  // A slot frees up in the same cycle it is accepted, so commit and accept may coincide.
  assign load = commit_i && (!valid_q || ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= commit_i && !load;
      if (load) begin
        data_q  <= word_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/input_serial_to_parallel.sv
// LSB-first serial deserializer: frame FSM, bit counter and shift register.
// Define INPUT_S2P_PARITY_EN to append an even-parity bit and a parity_err output.
module input_serial_to_parallel
  import input_s2p_pkg::*;
#(
  parameter int WIDTH_OUTPUT = 128
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    data_in,
  input  logic                    frame_start,
  output logic [WIDTH_OUTPUT-1:0] data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    sync_err
`ifdef INPUT_S2P_PARITY_EN
  ,
  output logic                    parity_err
`endif
);

  localparam int CW = cnt_w(WIDTH_OUTPUT);
`ifdef INPUT_S2P_PARITY_EN
  localparam int BW = WIDTH_OUTPUT + 1;
`else
  localparam int BW = WIDTH_OUTPUT;
`endif

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH_OUTPUT-1:0] shreg_q, shreg_d, shifted;
  logic                    sync_err_q, sync_err_d;
  logic                    commit;
  logic [BW-1:0]           word;
  logic [BW-1:0]           buf_data;

  assign shifted = {data_in, shreg_q[WIDTH_OUTPUT-1:1]};

`ifdef INPUT_S2P_PARITY_EN
  // Top bit carries the parity error flag so it loads together with the data.
  assign word = {^{shreg_q, data_in}, shreg_q};
`else
  assign word = shifted;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    sync_err_d = 1'b0;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          shreg_d = shifted;
          cnt_d   = CW'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shifted;
        if (frame_start) begin
          sync_err_d = 1'b1;
          cnt_d      = CW'(1);
        end else if (cnt_q == CW'(WIDTH_OUTPUT - 1)) begin
`ifdef INPUT_S2P_PARITY_EN
          cnt_d   = cnt_q + CW'(1);
          state_d = S_PARITY;
`else
          cnt_d   = '0;
          commit  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef INPUT_S2P_PARITY_EN
      S_PARITY: begin
        if (frame_start) begin
          sync_err_d = 1'b1;
          shreg_d    = shifted;
          cnt_d      = CW'(1);
          state_d    = S_SHIFT;
        end else begin
          cnt_d   = '0;
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sync_err_q <= sync_err_d;
    end
  end

  s2p_out_buffer #(.DW(BW)) u_buf (
    .clk      (CLK),
    .rst      (RST),
    .commit_i (commit),
    .word_i   (word),
    .ready_i  (out_ready),
    .data_o   (buf_data),
    .valid_o  (out_valid),
    .overrun_o(overrun)
  );

  assign data_out = buf_data[WIDTH_OUTPUT-1:0];
`ifdef INPUT_S2P_PARITY_EN
  assign parity_err = buf_data[WIDTH_OUTPUT];
`endif
  assign busy     = (state_q != S_IDLE);
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_input_serial_to_parallel.sv
// Directed bench for the 8-bit deserializer: framing, backpressure, resync,
// reset and (with INPUT_S2P_PARITY_EN) parity checking.
module tb_input_serial_to_parallel;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         data_in = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         sync_err;
`ifdef INPUT_S2P_PARITY_EN
  logic         parity_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ov_cnt, se_cnt, vld_cnt;

  always #5 CLK = ~CLK;

  input_serial_to_parallel #(.WIDTH_OUTPUT(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .data_in    (data_in),
    .frame_start(frame_start),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .sync_err   (sync_err)
`ifdef INPUT_S2P_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic fs, input logic d, input logic rdy);
    frame_start = fs;
    data_in     = d;
    out_ready   = rdy;
    @(posedge CLK);
    #1;
    ov_cnt  += int'(overrun);
    se_cnt  += int'(sync_err);
    vld_cnt += int'(out_valid);
  endtask

  task automatic clr_cnt();
    ov_cnt  = 0;
    se_cnt  = 0;
    vld_cnt = 0;
  endtask

  // Full frame LSB first; flip inverts the parity bit when parity is built in.
  task automatic send_frame(input logic [W-1:0] word, input logic flip,
                            input logic rdy_dur, input logic rdy_last);
`ifdef INPUT_S2P_PARITY_EN
    for (int i = 0; i < W; i++) drive(i == 0, word[i], rdy_dur);
    drive(1'b0, (^word) ^ flip, rdy_last);
`else
    for (int i = 0; i < W; i++) drive(i == 0, word[i], (i == W - 1) ? rdy_last : rdy_dur);
`endif
  endtask

  initial begin
    clr_cnt();
    // Reset state
    @(posedge CLK);
    #1;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_serr", 32'(sync_err), 32'h0);
    RST = 1'b0;

    // 1. Single frame 0xA5, latency check
    clr_cnt();
    drive(1'b1, 1'b1, 1'b1);
    chk("t1_busy", 32'(busy), 32'h1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
`ifdef INPUT_S2P_PARITY_EN
    chk("t6_vld_before_par", 32'(out_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    chk("t6_perr0", 32'(parity_err), 32'h0);
`endif
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(data_out), 32'hA5);
    chk("t1_vld_cycles", 32'(vld_cnt), 32'h1);
    chk("t1_busy_end", 32'(busy), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    chk("t1_drop", 32'(out_valid), 32'h0);

    // 2. Back-to-back frames under backpressure
    clr_cnt();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t2_data1", 32'(data_out), 32'h3C);
    chk("t2_valid1", 32'(out_valid), 32'h1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t2_ovr_now", 32'(overrun), 32'h1);
    chk("t2_data_held", 32'(data_out), 32'h3C);
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_ovr_pulse", 32'(overrun), 32'h0);
    chk("t2_ovr_cnt", 32'(ov_cnt), 32'h1);
    chk("t2_valid_held", 32'(out_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b1);
    chk("t2_accept", 32'(out_valid), 32'h0);

    // 3. Accept and commit on the same cycle
    clr_cnt();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    chk("t3_data", 32'(data_out), 32'h81);
    chk("t3_valid", 32'(out_valid), 32'h1);
    chk("t3_ovr", 32'(ov_cnt), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    chk("t3_drop", 32'(out_valid), 32'h0);

    // 4. Resync: restart at bit 4, then a full 0x5A frame
    clr_cnt();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    chk("t4_serr_cnt", 32'(se_cnt), 32'h1);
    chk("t4_data", 32'(data_out), 32'h5A);
    chk("t4_vld_cnt", 32'(vld_cnt), 32'h1);
    drive(1'b0, 1'b0, 1'b1);
    chk("t4_serr_idle", 32'(sync_err), 32'h0);

    // 5. Reset mid-frame discards the partial frame
    clr_cnt();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    RST = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    RST = 1'b0;
    chk("t5_data", 32'(data_out), 32'h0);
    chk("t5_valid", 32'(out_valid), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    clr_cnt();
    for (int i = 0; i < W + 1; i++) drive(1'b0, 1'b1, 1'b1);
    chk("t5_no_valid", 32'(vld_cnt), 32'h0);
    chk("t5_busy_end", 32'(busy), 32'h0);

`ifdef INPUT_S2P_PARITY_EN
    // 6. Parity error on a flipped parity bit
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    chk("t6_perr1", 32'(parity_err), 32'h1);
    chk("t6_data", 32'(data_out), 32'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
